// File: rtl/ge_pkg.sv
// Shared definitions for the ge_frame_max streaming maximum finder.
//   state_e   : frame FSM states
//   DEF_WIDTH : default sample width
//   DEF_IDX_W : default index width (nominal frame length 2^DEF_IDX_W)
package ge_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage : ge_pkg

// File: rtl/ge_cmp.sv
// Combinational unsigned greater-or-equal comparator cell.
//   a, b : WIDTH-bit unsigned operands
//   ge_c : 1 when a >= b (equality counts as ge)
module ge_cmp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge_c
);

  assign ge_c = (a >= b);

endmodule : ge_cmp

// File: rtl/ge_frame_max.sv
// Streaming maximum finder: tracks max/index/count over a valid/ready frame
// and presents the result on a valid/ready output at frame end.
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last : input sample stream
//   out_valid/out_ready         : result handshake
//   out_max/out_idx/out_count/out_ovf : frame maximum, its index, sample
//                                 count (saturating at 2^IDX_W), overflow flag
module ge_frame_max
  import ge_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_ovf
);

  localparam int unsigned COUNT_W = IDX_W + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   IDX_SAT = {IDX_W{1'b1}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic               accept_c;
  logic               ge_c;
  logic               cnt_full_c;
  logic [IDX_W-1:0]   pos_c;

  // Single comparator: new sample against running maximum.
  ge_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a    (in_data),
    .b    (max_q),
    .ge_c (ge_c)
  );

  assign accept_c   = in_valid && in_ready_q;
  assign cnt_full_c = (count_q == CNT_MAX);
  // Index of the incoming sample, pinned at the top index once saturated.
  assign pos_c      = cnt_full_c ? IDX_SAT : count_q[IDX_W-1:0];

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    idx_d       = idx_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          max_d   = in_data;
          idx_d   = '0;
          count_d = CNT_ONE;
          ovf_d   = 1'b0;
          if (in_last) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end

      ST_ACCUM: begin
        if (accept_c) begin
          // Ties take the newest index.
          if (ge_c) begin
            max_d = in_data;
            idx_d = pos_c;
          end
          if (cnt_full_c) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
          if (in_last) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      max_q       <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule : ge_frame_max

// File: tb/tb_ge_frame_max.sv
// Directed self-checking bench for ge_frame_max (WIDTH=4, IDX_W=4).
// Result vector layout: {out_valid, out_max[3:0], out_idx[3:0], out_count[4:0], out_ovf}.
module tb_ge_frame_max;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_max;
  logic [3:0] out_idx;
  logic [4:0] out_count;
  logic       out_ovf;

  int checks = 0;
  int errors = 0;

  ge_frame_max #(.WIDTH(4), .IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  wire [14:0] res = {out_valid, out_max, out_idx, out_count, out_ovf};

  // Offer one sample for one cycle; sampling point is #1 after the edge.
  task automatic send(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Let the pending result drain with out_ready already high.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (res !== 15'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got res=%h in_ready=%b, want res=0000 in_ready=1", res, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(4'd2, 1'b0);
    send(4'd0, 1'b0);
    send(4'd3, 1'b0);
    send(4'd1, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd3, 4'd2, 5'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=3 idx=2 cnt=4 ovf=0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_ready: got in_ready=%b, want 0", in_ready);
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ties();
    send(4'd3, 1'b0);
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    send(4'd1, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd5, 4'd2, 5'd4, 1'b0}) begin
      errors++;
      $display("FAIL ties: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=5 idx=2 cnt=4 ovf=0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    drain();
    send(4'd7, 1'b0);
    send(4'd7, 1'b0);
    send(4'd7, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd7, 4'd2, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL all_equal: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=7 idx=2 cnt=3 ovf=0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    drain();
  endtask

  task automatic test_single();
    send(4'd9, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd9, 4'd0, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL single: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=9 idx=0 cnt=1 ovf=0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    drain();
    send(4'd4, 1'b0);
    send(4'd6, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd6, 4'd1, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL after_single: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=6 idx=1 cnt=2 ovf=0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [14:0] want;
    want = {1'b1, 4'd2, 4'd1, 5'd2, 1'b0};
    out_ready = 1'b0;
    send(4'd1, 1'b0);
    send(4'd2, 1'b1);
    // Offer a large sample that must be ignored while the result is pending.
    in_valid = 1'b1;
    in_data  = 4'd15;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res !== want || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: got res=%h in_ready=%b, want res=%h in_ready=0", i, res, in_ready, want);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    send(4'd0, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd0, 4'd0, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_ignored: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=0 idx=0 cnt=1 ovf=0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send(4'd3, 1'b0);
    checks++;
    if (out_count !== 5'd16 || out_ovf !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_edge: got cnt=%0d ovf=%b v=%b, want cnt=16 ovf=0 v=0", out_count, out_ovf, out_valid);
    end
    send(4'd15, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd15, 4'd15, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL overflow: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=15 idx=15 cnt=16 ovf=1",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    send(4'd5, 1'b0);
    send(4'd6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res !== 15'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got res=%h in_ready=%b, want res=0000 in_ready=1", res, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'd1, 1'b0);
    send(4'd8, 1'b1);
    checks++;
    if (res !== {1'b1, 4'd8, 4'd1, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL after_reset: got v=%b max=%0d idx=%0d cnt=%0d ovf=%b, want v=1 max=8 idx=1 cnt=2 ovf=0",
               out_valid, out_max, out_idx, out_count, out_ovf);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ge_frame_max
